// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : thread_scheduler
//  Purpose  : Picks the hardware thread whose PC the fetch stage issues each
//             cycle in the barrel core. The search is round-robin and starts
//             after the last issued thread. Threads that are disabled,
//             waiting, halted or still inside their issue-spacing window are
//             skipped. A bubble (tid_valid = 0) goes out when no thread can
//             issue.
//  Ports    : clk, rst_n (async, active low)
//             en                   pipeline advance (0 freezes selection,
//                                  spacing counters and stall timers)
//             thread_en[N]         per-thread enable mask
//             stall_req/stall_tid/stall_cycles   move a thread into WAIT
//             wake_req/wake_tid    move a thread from WAIT back to RUN
//             halt_req/halt_tid    move a thread into HALT (sticky)
//             tid/tid_valid        registered issue slot
//             run_mask             per-thread RUN indication
//             all_halted           every enabled thread is in HALT
//  Config   : `define TS_STALL_TIMER_EN to add a per-thread auto-wake
//             down-counter loaded from stall_cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module thread_scheduler #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int MIN_SPACING  = 5,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_THREADS-1:0]  thread_en,
    input  logic                    stall_req,
    input  logic [BITS_THREADS-1:0] stall_tid,
    input  logic [CNT_WIDTH-1:0]    stall_cycles,
    input  logic                    wake_req,
    input  logic [BITS_THREADS-1:0] wake_tid,
    input  logic                    halt_req,
    input  logic [BITS_THREADS-1:0] halt_tid,
    output logic [BITS_THREADS-1:0] tid,
    output logic                    tid_valid,
    output logic [NUM_THREADS-1:0]  run_mask,
    output logic                    all_halted
);

    // Spacing counter only has to hold MIN_SPACING-1.
    localparam int c_SP_W = (MIN_SPACING > 1) ? $clog2(MIN_SPACING) : 1;
    localparam logic [c_SP_W-1:0] c_SPACING_RELOAD = c_SP_W'(MIN_SPACING - 1);
    // One extra bit so (last + k) cannot overflow before the wrap.
    localparam int c_IW = BITS_THREADS + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    logic [NUM_THREADS-1:0]  w_elig;
    logic [NUM_THREADS-1:0]  w_halted_or_off;
    logic                    w_found;
    logic [BITS_THREADS-1:0] w_sel;
    logic [c_IW-1:0]         w_idx;

    logic [BITS_THREADS-1:0] r_tid;
    logic                    r_tid_valid;
    logic [BITS_THREADS-1:0] r_last_tid;

`ifndef TS_STALL_TIMER_EN
    // The stall duration has no meaning without the auto-wake timers.
    logic w_unused_stall_cycles;
    assign w_unused_stall_cycles = ^stall_cycles;
`endif

    // ------------------------------------------------------------------------
    // Per-thread state: RUN/WAIT/HALT FSM, spacing counter, optional timer
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        state_t            r_state;
        logic [c_SP_W-1:0] r_spacing;
        logic              w_halt_hit;
        logic              w_stall_hit;
        logic              w_wake_hit;

        assign w_halt_hit  = halt_req  && (halt_tid  == BITS_THREADS'(gi));
        assign w_stall_hit = stall_req && (stall_tid == BITS_THREADS'(gi));
        assign w_wake_hit  = wake_req  && (wake_tid  == BITS_THREADS'(gi));

        // Eligibility looks only at registered state, so a request seen at
        // one edge first influences selection at the following edge.
        assign w_elig[gi] = (r_state == ST_RUN) && thread_en[gi] && (r_spacing == '0);
        assign run_mask[gi]        = (r_state == ST_RUN);
        assign w_halted_or_off[gi] = (r_state == ST_HALT) || !thread_en[gi];

`ifdef TS_STALL_TIMER_EN
        logic [CNT_WIDTH-1:0] r_timer;

        // Priority for one thread: halt > stall > wake > timer expiry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_RUN;
                r_timer <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_halt_hit) begin
                            r_state <= ST_HALT;
                        end else if (w_stall_hit) begin
                            r_state <= ST_WAIT;
                            r_timer <= stall_cycles;
                        end
                    end
                    ST_WAIT: begin
                        if (w_halt_hit) begin
                            r_state <= ST_HALT;
                            r_timer <= '0;
                        end else if (w_stall_hit) begin
                            r_timer <= stall_cycles;
                        end else if (w_wake_hit) begin
                            r_state <= ST_RUN;
                            r_timer <= '0;
                        end else if (en && (r_timer != '0)) begin
                            // A zero timer means "wait for wake_req only".
                            r_timer <= r_timer - 1'b1;
                            if (r_timer == CNT_WIDTH'(1)) begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HALT;
                    end
                endcase
            end
        end
`else
        // Priority for one thread: halt > stall > wake.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_halt_hit) begin
                            r_state <= ST_HALT;
                        end else if (w_stall_hit) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_halt_hit) begin
                            r_state <= ST_HALT;
                        end else if (!w_stall_hit && w_wake_hit) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_HALT;
                    end
                endcase
            end
        end
`endif

        // The issuing thread reloads its window; all others count down.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_spacing <= '0;
            end else if (en) begin
                if (w_found && (w_sel == BITS_THREADS'(gi))) begin
                    r_spacing <= c_SPACING_RELOAD;
                end else if (r_spacing != '0) begin
                    r_spacing <= r_spacing - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search starting one past the last issued thread
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_tid;
        w_idx   = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            w_idx = {1'b0, r_last_tid} + c_IW'(k);
            if (w_idx >= c_IW'(NUM_THREADS)) begin
                w_idx = w_idx - c_IW'(NUM_THREADS);
            end
            if (!w_found && w_elig[w_idx[BITS_THREADS-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[BITS_THREADS-1:0];
            end
        end
    end

    // Last issued thread resets to NUM_THREADS-1 so the first search begins
    // at thread 0; tid itself resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tid       <= '0;
            r_tid_valid <= 1'b0;
            r_last_tid  <= BITS_THREADS'(NUM_THREADS - 1);
        end else if (en) begin
            r_tid_valid <= w_found;
            if (w_found) begin
                r_tid      <= w_sel;
                r_last_tid <= w_sel;
            end
        end
    end

    assign tid        = r_tid;
    assign tid_valid  = r_tid_valid;
    // An empty enable mask is not reported as "all halted".
    assign all_halted = (|thread_en) && (&w_halted_or_off);

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_thread_scheduler
//  Purpose  : Scoreboard bench for thread_scheduler. A reference model that
//             tracks issue times, thread states and wake-up times pushes one
//             expected output set per clock edge; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_thread_scheduler;

    localparam int N  = 8;
    localparam int BT = 3;
    localparam int MS = 5;
    localparam int CW = 8;

    localparam int S_RUN  = 0;
    localparam int S_WAIT = 1;
    localparam int S_HALT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [N-1:0]  thread_en;
    logic          stall_req;
    logic [BT-1:0] stall_tid;
    logic [CW-1:0] stall_cycles;
    logic          wake_req;
    logic [BT-1:0] wake_tid;
    logic          halt_req;
    logic [BT-1:0] halt_tid;
    logic [BT-1:0] tid;
    logic          tid_valid;
    logic [N-1:0]  run_mask;
    logic          all_halted;

    always #5 clk = ~clk;

    thread_scheduler #(
        .NUM_THREADS (N),
        .BITS_THREADS(BT),
        .MIN_SPACING (MS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .thread_en   (thread_en),
        .stall_req   (stall_req),
        .stall_tid   (stall_tid),
        .stall_cycles(stall_cycles),
        .wake_req    (wake_req),
        .wake_tid    (wake_tid),
        .halt_req    (halt_req),
        .halt_tid    (halt_tid),
        .tid         (tid),
        .tid_valid   (tid_valid),
        .run_mask    (run_mask),
        .all_halted  (all_halted)
    );

    typedef struct packed {
        logic [BT-1:0] tid;
        logic          valid;
        logic [N-1:0]  mask;
        logic          ah;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model ----------------
    // Spacing is modelled as "en-cycles since last issue", timers as an
    // absolute en-cycle number at which the thread wakes (-1 = none).
    int m_state   [N];
    int m_last    [N];
    int m_wake_at [N];
    int m_en_cnt;
    int m_prev;
    int m_tid;
    bit m_valid;

    function automatic void model_reset();
        for (int t = 0; t < N; t++) begin
            m_state[t]   = S_RUN;
            m_last[t]    = -1000;
            m_wake_at[t] = -1;
        end
        m_en_cnt = 0;
        m_prev   = N - 1;
        m_tid    = 0;
        m_valid  = 1'b0;
    endfunction

    function automatic int timer_target();
`ifdef TS_STALL_TIMER_EN
        if (stall_cycles == '0) return -1;
        return m_en_cnt + int'(stall_cycles);
`else
        return -1;
`endif
    endfunction

    function automatic exp_t model_edge();
        exp_t e;
        bit   found = 1'b0;
        int   sel   = 0;
        int   t;
        bit   all_h;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                t = (m_prev + k) % N;
                if (!found && m_state[t] == S_RUN && thread_en[t] &&
                    (m_en_cnt + 1 - m_last[t] >= MS)) begin
                    found = 1'b1;
                    sel   = t;
                end
            end
            m_valid = found;
            if (found) begin
                m_tid      = sel;
                m_prev     = sel;
                m_last[sel] = m_en_cnt + 1;
            end
            m_en_cnt++;
        end
        for (int i = 0; i < N; i++) begin
            bit h = halt_req  && (int'(halt_tid)  == i);
            bit s = stall_req && (int'(stall_tid) == i);
            bit w = wake_req  && (int'(wake_tid)  == i);
            if (m_state[i] == S_RUN) begin
                if (h) m_state[i] = S_HALT;
                else if (s) begin
                    m_state[i]   = S_WAIT;
                    m_wake_at[i] = timer_target();
                end
            end else if (m_state[i] == S_WAIT) begin
                if (h) m_state[i] = S_HALT;
                else if (s) m_wake_at[i] = timer_target();
                else if (w) begin
                    m_state[i]   = S_RUN;
                    m_wake_at[i] = -1;
                end else if (en && m_wake_at[i] >= 0 && m_en_cnt == m_wake_at[i]) begin
                    m_state[i]   = S_RUN;
                    m_wake_at[i] = -1;
                end
            end
        end
        all_h = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.mask[i] = (m_state[i] == S_RUN);
            if (thread_en[i] && m_state[i] != S_HALT) all_h = 1'b0;
        end
        e.ah    = (|thread_en) && all_h;
        e.tid   = BT'(m_tid);
        e.valid = m_valid;
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("tid_valid",  int'(tid_valid),  int'(e.valid));
                check("tid",        int'(tid),        int'(e.tid));
                check("run_mask",   int'(run_mask),   int'(e.mask));
                check("all_halted", int'(all_halted), int'(e.ah));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        sb_q.push_back(model_edge());
        @(negedge clk);
    endtask

    task automatic clear_req();
        stall_req = 1'b0;
        wake_req  = 1'b0;
        halt_req  = 1'b0;
    endtask

    // Called at a negedge: reset asynchronously, check the cleared outputs,
    // hold for two clocks and release at a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        sb_q.delete();
        check("rst_tid",        int'(tid),        0);
        check("rst_tid_valid",  int'(tid_valid),  0);
        check("rst_run_mask",   int'(run_mask),   (1 << N) - 1);
        check("rst_all_halted", int'(all_halted), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : driver
        logic [N-1:0] v;
        rst_n        = 1'b0;
        en           = 1'b0;
        thread_en    = '1;
        stall_tid    = '0;
        stall_cycles = '0;
        wake_tid     = '0;
        halt_tid     = '0;
        clear_req();
        @(negedge clk);

        // T1: plain rotation 0..7,0
        do_reset();
        en = 1'b1;
        repeat (9) step();

        // T2: stall thread 3 with no timer, later wake it
        do_reset();
        repeat (3) step();
        stall_req = 1'b1; stall_tid = 3'd3; stall_cycles = '0;
        step();
        clear_req();
        repeat (10) step();
        wake_req = 1'b1; wake_tid = 3'd3;
        step();
        clear_req();
        repeat (10) step();

        // T3: single enabled thread issues every MIN_SPACING cycles
        do_reset();
        thread_en = 8'h01;
        repeat (15) step();
        thread_en = '1;

        // T4: halt beats wake on a waiting thread; halt everything
        do_reset();
        stall_req = 1'b1; stall_tid = 3'd2;
        step();
        clear_req();
        step();
        halt_req = 1'b1; halt_tid = 3'd2; wake_req = 1'b1; wake_tid = 3'd2;
        step();
        clear_req();
        repeat (4) step();
        wake_req = 1'b1; wake_tid = 3'd2;
        step();
        clear_req();
        repeat (8) step();
        for (int i = 0; i < N; i++) begin
            halt_req = 1'b1; halt_tid = BT'(i);
            step();
        end
        clear_req();
        repeat (6) step();

        // T5: freeze mid-rotation at tid 5
        do_reset();
        repeat (6) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (4) step();

`ifdef TS_STALL_TIMER_EN
        // T6: timed stall, including a frozen cycle
        do_reset();
        stall_req = 1'b1; stall_tid = 3'd1; stall_cycles = 8'd4;
        step();
        clear_req();
        repeat (8) step();
        stall_req = 1'b1; stall_tid = 3'd6; stall_cycles = 8'd3;
        step();
        clear_req();
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (6) step();
`endif

        // Randomised segments, each starting with a mid-operation reset
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            if ($urandom_range(0, 2) == 0) begin
                do v = N'($urandom); while (v == '0);
                thread_en = v;
            end else begin
                thread_en = '1;
            end
            for (int c = 0; c < 150; c++) begin
                en           = ($urandom_range(0, 3) != 0);
                stall_req    = ($urandom_range(0, 7) == 0);
                stall_tid    = BT'($urandom);
                stall_cycles = CW'($urandom_range(0, 6));
                wake_req     = ($urandom_range(0, 4) == 0);
                wake_tid     = BT'($urandom);
                halt_req     = ($urandom_range(0, 59) == 0);
                halt_tid     = BT'($urandom);
                if ($urandom_range(0, 49) == 0) begin
                    do v = N'($urandom); while (v == '0);
                    thread_en = v;
                end
                step();
            end
            clear_req();
        end

        clear_req();
        en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
